commit_unit: RTL and testbench

Per-thread in-order commit stage for the multithreaded pipeline, parametrised in thread count, register count and store-buffer depth. It sits after the TL stage and owns the per-thread expected-PC state. It decides commit vs. retry for each arriving instruction, drives register-file writeback and fetch redirects, and buffers committed stores in a FIFO. The FIFO drains to the d-cache through a valid/ready handshake.

---
 rtl/commit_unit_pkg.sv | 25 ++
 rtl/commit_unit_store_queue.sv | 81 ++++++++
 rtl/commit_unit.sv | 174 +++++++++++++++++
 tb/tb_commit_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_unit_pkg.sv
// Shared types and defaults for the commit stage: address/word types and the
// store-buffer entry pushed by commit_unit into store_queue.
package commit_unit_pkg;

  localparam int unsigned default_threads = 8;
  localparam int unsigned default_regs    = 32;
  localparam int unsigned store_depth     = 4;

  typedef logic [$clog2(default_threads)-1:0] threadid_t;
  typedef logic [$clog2(default_regs)-1:0]    regid_t;
  typedef logic [31:0]                        vptr_t;
  typedef logic [31:0]                        word_t;
  typedef logic [19:0]                        pptr_t;

  typedef struct packed {
    pptr_t addr;
    word_t data;
    logic  isbyte;
  } store_entry_t;

  function automatic logic is_taken(input logic jump, input logic branch, input logic isequal);
    return jump & (~branch | isequal);
  endfunction

endpackage

// File: rtl/commit_unit_store_queue.sv
// Store buffer between commit and the d-cache: a DEPTH-entry FIFO of
// store_entry_t with registered valid/full flags.
module store_queue
  import commit_unit_pkg::*;
#(
  parameter int unsigned DEPTH = store_depth
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  store_entry_t entry,
  output logic         full,
  output logic         valid,
  input  logic         ready,
  output store_entry_t head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Handshake: head transfers on a cycle where valid & ready are both high;
  // while valid & ~ready the head and valid hold unchanged. Full is the
  // registered count, so a same-cycle pop never admits a push.
  store_entry_t      mem_q [DEPTH];
  store_entry_t      mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              valid_q, valid_d;
  logic              do_push, do_pop;

  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = valid_q & ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage carries no reset; valid_q gates what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full  = full_q;
  assign valid = valid_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/commit_unit.sv
// Per-thread in-order commit: classifies each writeback as stale/commit/retry,
// drives RF writes, fetch redirects and the store buffer. Define COMMIT_STATS_EN
// to add commit/retry counters.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int unsigned N_THREADS   = default_threads,
  parameter int unsigned N_REGS      = default_regs,
  parameter int unsigned STORE_DEPTH = store_depth,
  parameter logic [31:0] RESET_PC    = 32'h0000_1000,
  localparam int unsigned TW = $clog2(N_THREADS),
  localparam int unsigned RW = $clog2(N_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [TW-1:0] wb_thread,
  input  logic          wb_isvalid,
  input  logic [31:0]   wb_pc,
  input  logic [RW-1:0] wb_dst,
  input  logic [31:0]   wb_data,
  input  logic [31:0]   wb_mul,
  input  logic [31:0]   wb_r2,
  input  logic          wb_isequal,
  input  logic          wb_flag_reg,
  input  logic          wb_flag_mul,
  input  logic          wb_flag_jump,
  input  logic          wb_flag_branch,
  input  logic          wb_flag_store,
  input  logic          wb_flag_isbyte,
  output logic          rf_we,
  output logic [TW-1:0] rf_thread,
  output logic [RW-1:0] rf_dst,
  output logic [31:0]   rf_wdata,
  output logic          redirect_en,
  output logic [TW-1:0] redirect_thread,
  output logic [31:0]   redirect_pc,
  output logic          st_valid,
  input  logic          st_ready,
  output logic [19:0]   st_addr,
  output logic [31:0]   st_data,
  output logic          st_isbyte,
  output logic          st_full,
  output logic [31:0]   stat_commit,
  output logic [31:0]   stat_retry
);

  vptr_t         exp_pc_q [N_THREADS];
  vptr_t         exp_pc_d [N_THREADS];
  logic          rf_we_q, rf_we_d;
  logic [TW-1:0] rf_thread_q, rf_thread_d;
  logic [RW-1:0] rf_dst_q, rf_dst_d;
  word_t         rf_wdata_q, rf_wdata_d;
  logic          redirect_en_q, redirect_en_d;
  logic [TW-1:0] redirect_thread_q, redirect_thread_d;
  vptr_t         redirect_pc_q, redirect_pc_d;

  vptr_t         cur_pc;
  logic          is_match, is_commit, is_retry, taken;
  logic          sq_push, sq_full, sq_valid;
  store_entry_t  sq_entry, sq_head;

  always_comb begin
    cur_pc    = exp_pc_q[wb_thread];
    taken     = is_taken(wb_flag_jump, wb_flag_branch, wb_isequal);
    is_match  = wb_valid & (wb_pc == cur_pc);
    // A store that finds the buffer full is not lost: it retries via redirect.
    is_commit = is_match & wb_isvalid & ~(wb_flag_store & sq_full);
    is_retry  = is_match & ~is_commit;

    exp_pc_d = exp_pc_q;
    if (is_commit) begin
      exp_pc_d[wb_thread] = taken ? wb_data : cur_pc + 32'd4;
    end

    rf_we_d     = is_commit & wb_flag_reg;
    rf_thread_d = rf_thread_q;
    rf_dst_d    = rf_dst_q;
    rf_wdata_d  = rf_wdata_q;
    if (rf_we_d) begin
      rf_thread_d = wb_thread;
      rf_dst_d    = wb_dst;
      rf_wdata_d  = wb_flag_mul ? wb_mul : wb_data;
    end

    redirect_en_d     = is_retry | (is_commit & taken);
    redirect_thread_d = redirect_thread_q;
    redirect_pc_d     = redirect_pc_q;
    if (redirect_en_d) begin
      redirect_thread_d = wb_thread;
      redirect_pc_d     = is_retry ? cur_pc : wb_data;
    end

    sq_push         = is_commit & wb_flag_store;
    sq_entry.addr   = wb_data[19:0];
    sq_entry.data   = wb_r2;
    sq_entry.isbyte = wb_flag_isbyte;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(N_THREADS); i++) begin
        exp_pc_q[i] <= RESET_PC;
      end
      rf_we_q           <= 1'b0;
      rf_thread_q       <= '0;
      rf_dst_q          <= '0;
      rf_wdata_q        <= '0;
      redirect_en_q     <= 1'b0;
      redirect_thread_q <= '0;
      redirect_pc_q     <= '0;
    end else begin
      exp_pc_q          <= exp_pc_d;
      rf_we_q           <= rf_we_d;
      rf_thread_q       <= rf_thread_d;
      rf_dst_q          <= rf_dst_d;
      rf_wdata_q        <= rf_wdata_d;
      redirect_en_q     <= redirect_en_d;
      redirect_thread_q <= redirect_thread_d;
      redirect_pc_q     <= redirect_pc_d;
    end
  end

  store_queue #(.DEPTH(STORE_DEPTH)) u_store_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (sq_push),
    .entry (sq_entry),
    .full  (sq_full),
    .valid (sq_valid),
    .ready (st_ready),
    .head  (sq_head)
  );

`ifdef COMMIT_STATS_EN
  logic [31:0] stat_commit_q, stat_commit_d;
  logic [31:0] stat_retry_q, stat_retry_d;

  always_comb begin
    stat_commit_d = stat_commit_q + {31'd0, is_commit};
    stat_retry_d  = stat_retry_q + {31'd0, is_retry};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_commit_q <= '0;
      stat_retry_q  <= '0;
    end else begin
      stat_commit_q <= stat_commit_d;
      stat_retry_q  <= stat_retry_d;
    end
  end

  assign stat_commit = stat_commit_q;
  assign stat_retry  = stat_retry_q;
`else
  assign stat_commit = '0;
  assign stat_retry  = '0;
`endif

  assign rf_we           = rf_we_q;
  assign rf_thread       = rf_thread_q;
  assign rf_dst          = rf_dst_q;
  assign rf_wdata        = rf_wdata_q;
  assign redirect_en     = redirect_en_q;
  assign redirect_thread = redirect_thread_q;
  assign redirect_pc     = redirect_pc_q;
  assign st_valid        = sq_valid;
  assign st_addr         = sq_head.addr;
  assign st_data         = sq_head.data;
  assign st_isbyte       = sq_head.isbyte;
  assign st_full         = sq_full;

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_commit_unit;

  localparam int          N_THREADS = 8;
  localparam int          N_REGS    = 32;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [2:0]  wb_thread;
  logic        wb_isvalid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data, wb_mul, wb_r2;
  logic        wb_isequal, wb_flag_reg, wb_flag_mul, wb_flag_jump;
  logic        wb_flag_branch, wb_flag_store, wb_flag_isbyte;
  logic        rf_we;
  logic [2:0]  rf_thread;
  logic [4:0]  rf_dst;
  logic [31:0] rf_wdata;
  logic        redirect_en;
  logic [2:0]  redirect_thread;
  logic [31:0] redirect_pc;
  logic        st_valid, st_ready;
  logic [19:0] st_addr;
  logic [31:0] st_data;
  logic        st_isbyte, st_full;
  logic [31:0] stat_commit, stat_retry;

  commit_unit #(
    .N_THREADS(N_THREADS), .N_REGS(N_REGS), .STORE_DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_thread(wb_thread), .wb_isvalid(wb_isvalid), .wb_pc(wb_pc),
    .wb_dst(wb_dst), .wb_data(wb_data), .wb_mul(wb_mul), .wb_r2(wb_r2),
    .wb_isequal(wb_isequal), .wb_flag_reg(wb_flag_reg), .wb_flag_mul(wb_flag_mul),
    .wb_flag_jump(wb_flag_jump), .wb_flag_branch(wb_flag_branch),
    .wb_flag_store(wb_flag_store), .wb_flag_isbyte(wb_flag_isbyte),
    .rf_we(rf_we), .rf_thread(rf_thread), .rf_dst(rf_dst), .rf_wdata(rf_wdata),
    .redirect_en(redirect_en), .redirect_thread(redirect_thread), .redirect_pc(redirect_pc),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_isbyte(st_isbyte), .st_full(st_full),
    .stat_commit(stat_commit), .stat_retry(stat_retry)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]  m_pc [N_THREADS];
  logic [52:0]  exp_q [$];
  logic         m_rf_we, m_redir;
  logic [2:0]   m_rf_thread, m_redir_thread;
  logic [4:0]   m_rf_dst;
  logic [31:0]  m_rf_wdata, m_redir_pc;
  logic [31:0]  m_commit, m_retry;
  bit           chk_en = 0;
  bit           m_full, m_pop, m_push, m_taken;
  logic [52:0]  m_entry;

  always @(posedge clk) begin : model
    if (!rst) begin
      for (int t = 0; t < N_THREADS; t++) m_pc[t] = RESET_PC;
      exp_q.delete();
      m_rf_we  = 0;
      m_redir  = 0;
      m_commit = 0;
      m_retry  = 0;
      chk_en   = 1;
    end else begin
      m_full  = (exp_q.size() == DEPTH);
      m_pop   = (exp_q.size() != 0) && st_ready;
      m_push  = 0;
      m_rf_we = 0;
      m_redir = 0;
      if (wb_valid && wb_pc == m_pc[wb_thread]) begin
        if (wb_isvalid && !(wb_flag_store && m_full)) begin
          m_commit = m_commit + 1;
          m_taken  = wb_flag_jump && (!wb_flag_branch || wb_isequal);
          if (m_taken) begin
            m_redir        = 1;
            m_redir_thread = wb_thread;
            m_redir_pc     = wb_data;
            m_pc[wb_thread] = wb_data;
          end else begin
            m_pc[wb_thread] = m_pc[wb_thread] + 4;
          end
          if (wb_flag_reg) begin
            m_rf_we     = 1;
            m_rf_thread = wb_thread;
            m_rf_dst    = wb_dst;
            m_rf_wdata  = wb_flag_mul ? wb_mul : wb_data;
          end
          if (wb_flag_store) begin
            m_push  = 1;
            m_entry = {wb_data[19:0], wb_r2, wb_flag_isbyte};
          end
        end else begin
          m_retry        = m_retry + 1;
          m_redir        = 1;
          m_redir_thread = wb_thread;
          m_redir_pc     = m_pc[wb_thread];
        end
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(m_entry);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("rf_we", {31'd0, rf_we}, {31'd0, m_rf_we});
      if (m_rf_we) begin
        check("rf_thread", {29'd0, rf_thread}, {29'd0, m_rf_thread});
        check("rf_dst", {27'd0, rf_dst}, {27'd0, m_rf_dst});
        check("rf_wdata", rf_wdata, m_rf_wdata);
      end
      check("redirect_en", {31'd0, redirect_en}, {31'd0, m_redir});
      if (m_redir) begin
        check("redirect_thread", {29'd0, redirect_thread}, {29'd0, m_redir_thread});
        check("redirect_pc", redirect_pc, m_redir_pc);
      end
      check("st_valid", {31'd0, st_valid}, {31'd0, exp_q.size() != 0});
      check("st_full", {31'd0, st_full}, {31'd0, exp_q.size() == DEPTH});
      if (exp_q.size() != 0) begin
        check("st_addr", {12'd0, st_addr}, {12'd0, exp_q[0][52:33]});
        check("st_data", st_data, exp_q[0][32:1]);
        check("st_isbyte", {31'd0, st_isbyte}, {31'd0, exp_q[0][0]});
      end
`ifdef COMMIT_STATS_EN
      check("stat_commit", stat_commit, m_commit);
      check("stat_retry", stat_retry, m_retry);
`else
      check("stat_commit", stat_commit, 32'd0);
      check("stat_retry", stat_retry, 32'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int th, input logic [31:0] pc, input logic isv,
                       input logic freg, input logic fst, input logic fj,
                       input logic fb, input logic feq, input logic [4:0] dst,
                       input logic [31:0] data, input logic [31:0] r2, input logic byt);
    @(negedge clk);
    wb_valid       = 1'b1;
    wb_thread      = 3'(th);
    wb_pc          = pc;
    wb_isvalid     = isv;
    wb_flag_reg    = freg;
    wb_flag_store  = fst;
    wb_flag_jump   = fj;
    wb_flag_branch = fb;
    wb_isequal     = feq;
    wb_flag_mul    = 1'b0;
    wb_flag_isbyte = byt;
    wb_dst         = dst;
    wb_data        = data;
    wb_mul         = $urandom;
    wb_r2          = r2;
  endtask

  task automatic idle();
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic drive_random();
    int th;
    @(negedge clk);
    th             = $urandom_range(0, N_THREADS - 1);
    wb_valid       = ($urandom_range(0, 9) < 8);
    wb_thread      = 3'(th);
    wb_pc          = ($urandom_range(0, 9) < 8) ? m_pc[th] : m_pc[th] + 32'(4 * $urandom_range(1, 3));
    wb_isvalid     = ($urandom_range(0, 9) < 8);
    wb_flag_reg    = $urandom_range(0, 1);
    wb_flag_mul    = $urandom_range(0, 1);
    wb_flag_store  = ($urandom_range(0, 2) == 0);
    wb_flag_jump   = ($urandom_range(0, 4) == 0);
    wb_flag_branch = $urandom_range(0, 1);
    wb_isequal     = $urandom_range(0, 1);
    wb_flag_isbyte = $urandom_range(0, 1);
    wb_dst         = 5'($urandom_range(0, N_REGS - 1));
    wb_data        = $urandom & 32'hFFFF_FFFC;
    wb_mul         = $urandom;
    wb_r2          = $urandom;
    st_ready       = ($urandom_range(0, 2) != 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    rst = 1'b0; st_ready = 1'b0;
    wb_valid = 0; wb_thread = 0; wb_isvalid = 0; wb_pc = 0; wb_dst = 0;
    wb_data = 0; wb_mul = 0; wb_r2 = 0; wb_isequal = 0; wb_flag_reg = 0;
    wb_flag_mul = 0; wb_flag_jump = 0; wb_flag_branch = 0; wb_flag_store = 0;
    wb_flag_isbyte = 0;
    repeat (2) @(negedge clk);
    check("reset_rf_we", {31'd0, rf_we}, 32'd0);
    check("reset_redirect_en", {31'd0, redirect_en}, 32'd0);
    check("reset_st_valid", {31'd0, st_valid}, 32'd0);
    check("reset_st_full", {31'd0, st_full}, 32'd0);
    rst = 1'b1;

    // simple register commit on thread 2
    drive(2, 32'h1000, 1, 1, 0, 0, 0, 0, 5'd5, 32'd7, 32'd0, 0);
    idle();
    check("t1_rf_we", {31'd0, rf_we}, 32'd1);
    check("t1_rf_thread", {29'd0, rf_thread}, 32'd2);
    check("t1_rf_dst", {27'd0, rf_dst}, 32'd5);
    check("t1_rf_wdata", rf_wdata, 32'd7);
    check("t1_model_pc2", m_pc[2], 32'h1004);

    // retry then commit on thread 0
    drive(0, 32'h1000, 0, 1, 0, 0, 0, 0, 5'd1, 32'h55, 32'd0, 0);
    idle();
    check("t2_redirect_en", {31'd0, redirect_en}, 32'd1);
    check("t2_redirect_pc", redirect_pc, 32'h1000);
    check("t2_no_rf_we", {31'd0, rf_we}, 32'd0);
    drive(0, 32'h1000, 1, 1, 0, 0, 0, 0, 5'd1, 32'h55, 32'd0, 0);
    idle();
    check("t2_commit_rf_we", {31'd0, rf_we}, 32'd1);
    check("t2_commit_wdata", rf_wdata, 32'h55);

    // taken branch on thread 1, then stale, then target commits
    drive(1, 32'h1000, 1, 0, 0, 1, 1, 1, 5'd0, 32'h2000, 32'd0, 0);
    idle();
    check("t3_redirect_en", {31'd0, redirect_en}, 32'd1);
    check("t3_redirect_pc", redirect_pc, 32'h2000);
    drive(1, 32'h1004, 1, 1, 0, 0, 0, 0, 5'd3, 32'h11, 32'd0, 0);
    idle();
    check("t3_stale_rf_we", {31'd0, rf_we}, 32'd0);
    check("t3_stale_redirect", {31'd0, redirect_en}, 32'd0);
    drive(1, 32'h2000, 1, 1, 0, 0, 0, 0, 5'd3, 32'h22, 32'd0, 0);
    idle();
    check("t3_target_rf_we", {31'd0, rf_we}, 32'd1);
    check("t3_target_wdata", rf_wdata, 32'h22);

    // five stores into a four-deep buffer with the d-cache stalled
    for (int i = 0; i < 5; i++)
      drive(4, 32'h1000 + 32'(4 * i), 1, 0, 1, 0, 0, 0, 5'd0,
            32'hFFF5_0000 + 32'(16 * i), 32'hD000_0000 + 32'(i), 1'(i));
    idle();
    check("t4_st_full", {31'd0, st_full}, 32'd1);
    check("t4_fifth_retry", {31'd0, redirect_en}, 32'd1);
    check("t4_fifth_retry_pc", redirect_pc, 32'h1010);
    check("t4_model_pc4", m_pc[4], 32'h1010);
    st_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_valid", {31'd0, st_valid}, 32'd1);
      check("t4_drain_addr", {12'd0, st_addr}, 32'h0005_0000 + 32'(16 * i));
      check("t4_drain_data", st_data, 32'hD000_0000 + 32'(i));
      check("t4_drain_isbyte", {31'd0, st_isbyte}, 32'(i % 2));
      @(negedge clk);
    end
    check("t4_drained", {31'd0, st_valid}, 32'd0);

    // interleaved threads 0 and 3
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(0, 32'h1004 + 32'(4 * (i / 2)), 1, 1, 0, 0, 0, 0, 5'd2, 32'(i), 32'd0, 0);
      else            drive(3, 32'h1000 + 32'(4 * (i / 2)), 1, 1, 0, 0, 0, 0, 5'd4, 32'(i), 32'd0, 0);
    end
    idle();
    check("t5_rf_wdata_last", rf_wdata, 32'd7);
    check("t5_model_pc0", m_pc[0], 32'h1014);
    check("t5_model_pc3", m_pc[3], 32'h1010);

    // reset drops buffered stores
    st_ready = 1'b0;
    drive(5, 32'h1000, 1, 0, 1, 0, 0, 0, 5'd0, 32'h0000_0100, 32'h1, 0);
    drive(5, 32'h1004, 1, 0, 1, 0, 0, 0, 5'd0, 32'h0000_0104, 32'h2, 0);
    idle();
    check("t6_st_valid_before", {31'd0, st_valid}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t6_st_valid_after", {31'd0, st_valid}, 32'd0);
    check("t6_st_full_after", {31'd0, st_full}, 32'd0);

    // commit/retry counters
    for (int i = 0; i < 10; i++)
      drive(6, 32'h1000 + 32'(4 * i), 1, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
    for (int i = 0; i < 3; i++)
      drive(6, 32'h1028, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
    idle();
`ifdef COMMIT_STATS_EN
    check("t7_stat_commit", stat_commit, 32'd10);
    check("t7_stat_retry", stat_retry, 32'd3);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t7_stat_commit_rst", stat_commit, 32'd0);
    check("t7_stat_retry_rst", stat_retry, 32'd0);
`else
    check("t7_stat_commit_tied", stat_commit, 32'd0);
    check("t7_stat_retry_tied", stat_retry, 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) drive_random();
    idle();
    st_ready = 1'b1;
    repeat (DEPTH + 2) @(negedge clk);
    check("final_drained", {31'd0, st_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
